vector_list_sequencer: RTL

Frame-level controller for the vector memory: on each frame start it walks the vector list from address 0, fetches one entry per step from the synchronous vector RAM, and offers each decoded vector to the line drawer over a valid/ready handshake. It owns the memory read address counter (zero, increment, hold) and stops at the end-of-list marker or at the top of the address space. It sits between the frame timing logic and the vector memory / line-drawing datapath.

---
 rtl/vector_list_sequencer_pkg.sv | 51 +++++
 rtl/vector_list_sequencer_if.sv | 52 +++++
 rtl/vector_list_sequencer_entry_decode.sv | 30 +++
 rtl/vector_list_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vector_list_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : vector_pkg                                                        |
// | Purpose : Shared types and vector-entry layout helpers for the vector list  |
// |           sequencer and its neighbours (line drawer, vector memory).        |
// |           Entry layout, MSB..LSB: eol, draw, x[CW], y[CW].                  |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package vector_pkg;

  // Sequencer control states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OFFER = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Address counter control issued by the FSM
  typedef enum logic [1:0] {
    ADR_HOLD = 2'd0,
    ADR_ZERO = 2'd1,
    ADR_INC  = 2'd2
  } adr_op_t;

  // Memory word width for a given coordinate width
  function automatic int entry_width(input int cw);
    return 2 * cw + 2;
  endfunction

  // Field positions inside one memory word
  function automatic int eol_bit(input int cw);
    return 2 * cw + 1;
  endfunction

  function automatic int draw_bit(input int cw);
    return 2 * cw;
  endfunction

  function automatic int x_lsb(input int cw);
    return cw;
  endfunction

  function automatic int y_lsb(input int cw);
    return 0 * cw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_list_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : vector_list_sequencer_if                                        |
// | Purpose   : Bundles the vector-memory read port and the vector handshake    |
// |             towards the line drawer.                                        |
// | Signals   : mem_adr   seq -> mem   read address                             |
// |             mem_data  mem -> seq   read data, one cycle after mem_adr       |
// |             vec_x/y   seq -> draw  end-point coordinates                    |
// |             vec_draw  seq -> draw  1 = beam on, 0 = move                    |
// |             vec_valid seq -> draw  fields valid                             |
// |             vec_ready draw -> seq  vector accepted                          |
// | Modports  : master (sequencer side), slave (memory / line drawer side)      |
// | Rev       : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface vector_list_sequencer_if
  import vector_pkg::*;
#(
  parameter int ADDRESSWIDTH = 10,
  parameter int COORDWIDTH   = 8
);

  logic [ADDRESSWIDTH-1:0]            mem_adr;
  logic [entry_width(COORDWIDTH)-1:0] mem_data;
  logic [COORDWIDTH-1:0]              vec_x;
  logic [COORDWIDTH-1:0]              vec_y;
  logic                               vec_draw;
  logic                               vec_valid;
  logic                               vec_ready;

  modport master (
    output mem_adr,
    input  mem_data,
    output vec_x,
    output vec_y,
    output vec_draw,
    output vec_valid,
    input  vec_ready
  );

  modport slave (
    input  mem_adr,
    output mem_data,
    input  vec_x,
    input  vec_y,
    input  vec_draw,
    input  vec_valid,
    output vec_ready
  );

endinterface
`default_nettype wire

// File: rtl/vector_list_sequencer_entry_decode.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vector_entry_decode                                               |
// | Purpose : Combinational split of one vector-memory word into its fields.    |
// | Ports   : i_entry  memory word                                              |
// |           o_eol    end-of-list marker                                       |
// |           o_draw   beam on / move                                           |
// |           o_x/o_y  end-point coordinates                                    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module vector_entry_decode
  import vector_pkg::*;
#(
  parameter int COORDWIDTH = 8
) (
  input  wire logic [entry_width(COORDWIDTH)-1:0] i_entry,
  output logic                                    o_eol,
  output logic                                    o_draw,
  output logic [COORDWIDTH-1:0]                   o_x,
  output logic [COORDWIDTH-1:0]                   o_y
);

  assign o_eol  = i_entry[eol_bit(COORDWIDTH)];
  assign o_draw = i_entry[draw_bit(COORDWIDTH)];
  assign o_x    = i_entry[x_lsb(COORDWIDTH) +: COORDWIDTH];
  assign o_y    = i_entry[y_lsb(COORDWIDTH) +: COORDWIDTH];

endmodule
`default_nettype wire

// File: rtl/vector_list_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vector_list_sequencer                                             |
// | Purpose : Per frame, walks the vector list from address 0, fetching one     |
// |           entry per step from a synchronous RAM and offering each decoded   |
// |           vector to the line drawer over valid/ready. Stops at the          |
// |           end-of-list marker or after the top address (never wraps).        |
// | Ports   : clk, rst         clock, synchronous active-high reset             |
// |           i_frame_start    one-cycle request for a new pass                 |
// |           io_bus           memory read port + vector handshake (master)     |
// |           o_busy           pass in progress (state != IDLE)                 |
// |           o_frame_done     one-cycle pulse at end of pass                   |
// |           o_overrun        one-cycle pulse: frame_start while busy          |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int ADDRESSWIDTH = 10,
  parameter int COORDWIDTH   = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_frame_start,
  vector_list_sequencer_if.master io_bus,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_overrun
);

  localparam logic [ADDRESSWIDTH-1:0] C_ADR_ONE = {{(ADDRESSWIDTH-1){1'b0}}, 1'b1};

  state_t                  r_state;
  state_t                  w_state_nxt;
  adr_op_t                 w_adr_op;
  logic [ADDRESSWIDTH-1:0] r_adr;
  logic [COORDWIDTH-1:0]   r_x;
  logic [COORDWIDTH-1:0]   r_y;
  logic                    r_draw;
  logic                    r_valid;
  logic                    r_frame_done;
  logic                    r_overrun;

  logic                    w_eol;
  logic                    w_draw;
  logic [COORDWIDTH-1:0]   w_x;
  logic [COORDWIDTH-1:0]   w_y;
  logic                    w_load_vec;
  logic                    w_valid_nxt;
  logic                    w_accept;
  logic                    w_adr_last;

  vector_entry_decode #(
    .COORDWIDTH (COORDWIDTH)
  ) u_decode (
    .i_entry (io_bus.mem_data),
    .o_eol   (w_eol),
    .o_draw  (w_draw),
    .o_x     (w_x),
    .o_y     (w_y)
  );

  assign w_accept   = r_valid & io_bus.vec_ready;
  // Top of the address space: the pass ends here rather than wrapping to 0
  assign w_adr_last = &r_adr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_adr_op    = ADR_HOLD;
    w_load_vec  = 1'b0;
    w_valid_nxt = r_valid;
    unique case (r_state)
      ST_IDLE: begin
        if (i_frame_start) begin
          w_adr_op    = ADR_ZERO;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Address is stable this cycle; the RAM registers the word
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_eol) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_load_vec  = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          if (w_adr_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_adr_op    = ADR_INC;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address counter, output vector registers and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_draw       <= 1'b0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      unique case (w_adr_op)
        ADR_ZERO: r_adr <= '0;
        ADR_INC:  r_adr <= r_adr + C_ADR_ONE;
        default:  r_adr <= r_adr;
      endcase
      if (w_load_vec) begin
        r_x    <= w_x;
        r_y    <= w_y;
        r_draw <= w_draw;
      end
      r_valid      <= w_valid_nxt;
      // Pulse is high for exactly the DONE cycle
      r_frame_done <= (w_state_nxt == ST_DONE);
      // A request outside IDLE is dropped; the running pass is unaffected
      r_overrun    <= i_frame_start & (r_state != ST_IDLE);
    end
  end

  assign io_bus.mem_adr   = r_adr;
  assign io_bus.vec_x     = r_x;
  assign io_bus.vec_y     = r_y;
  assign io_bus.vec_draw  = r_draw;
  assign io_bus.vec_valid = r_valid;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_frame_done     = r_frame_done;
  assign o_overrun        = r_overrun;

endmodule
`default_nettype wire
